regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the RV32I integer register file. It shares the file's single write port between two requesters: the ALU result path (requester 0) and the load/store unit load-return path (requester 1). Requests use a valid/ready handshake, and grants alternate round-robin when both requesters are valid. The block drives the write port from registered outputs and optionally tracks which destination registers have a write outstanding. It sits between execute/LSU and the register file.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/rr_arb2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the register-file write-back path.
package rv32i_pkg;

    localparam int XLEN     = 32;
    localparam int IDX_W    = 5;
    localparam int NUM_REGS = 32;

    // Requester positions in the arbiter request/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    // One write-back request as presented to the register file port
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage : rv32i_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The priority pointer
// flop lives in the parent so that reset and hold behaviour stay there.
module rr_arb2
    import rv32i_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       next_prio
);

    // Grant the lone requester, or the pointed-to one on contention; the
    // pointer then moves to whichever side lost (or holds when idle).
    always_comb begin
        gnt       = 2'b00;
        next_prio = prio;
        if (req[REQ_ALU] && req[REQ_LSU]) begin
            if (prio) begin
                gnt[REQ_LSU] = 1'b1;
            end else begin
                gnt[REQ_ALU] = 1'b1;
            end
        end else begin
            gnt = req;
        end
        if (gnt[REQ_ALU]) begin
            next_prio = 1'b1;
        end else if (gnt[REQ_LSU]) begin
            next_prio = 1'b0;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the RV32I register file: shares the single write
// port between the ALU result path and the LSU load-return path with
// round-robin grants, registers the winning write, and (when the macro
// WB_SCOREBOARD_EN is defined) tracks per-register outstanding writes.
module regfile_wb_arbiter #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int IDX_W = rv32i_pkg::IDX_W
) (
    input  logic                         clkin,
    input  logic                         nrst_in,
    input  logic                         alu_valid_in,
    input  logic [IDX_W-1:0]             alu_idx_in,
    input  logic [XLEN-1:0]              alu_data_in,
    output logic                         alu_ready_out,
    input  logic                         lsu_valid_in,
    input  logic [IDX_W-1:0]             lsu_idx_in,
    input  logic [XLEN-1:0]              lsu_data_in,
    output logic                         lsu_ready_out,
    input  logic                         issue_valid_in,
    input  logic [IDX_W-1:0]             issue_idx_in,
    output logic                         wr_en_out,
    output logic [IDX_W-1:0]             wr_idx_out,
    output logic [XLEN-1:0]              wr_data_out,
    output logic [rv32i_pkg::NUM_REGS-1:0] busy_out
);

    import rv32i_pkg::*;

    logic [1:0]       req_p0;
    logic [1:0]       gnt_p0;
    logic             prio;
    logic             next_prio_p0;
    logic             acc_p0;
    logic [IDX_W-1:0] sel_idx_p0;
    logic [XLEN-1:0]  sel_data_p0;

    logic             wr_en_p1;
    logic [IDX_W-1:0] wr_idx_p1;
    logic [XLEN-1:0]  wr_data_p1;

    assign req_p0[REQ_ALU] = alu_valid_in;
    assign req_p0[REQ_LSU] = lsu_valid_in;

    rr_arb2 u_arb (
        .req       (req_p0),
        .prio      (prio),
        .gnt       (gnt_p0),
        .next_prio (next_prio_p0)
    );

    // Stage p0: accept and select. Readies are masked during reset so no
    // requester believes it was accepted while the pipeline is being cleared.
    always_comb begin
        alu_ready_out = nrst_in & gnt_p0[REQ_ALU];
        lsu_ready_out = nrst_in & gnt_p0[REQ_LSU];
        acc_p0        = nrst_in & (gnt_p0[REQ_ALU] | gnt_p0[REQ_LSU]);
        sel_idx_p0    = alu_idx_in;
        sel_data_p0   = alu_data_in;
        if (gnt_p0[REQ_LSU]) begin
            sel_idx_p0  = lsu_idx_in;
            sel_data_p0 = lsu_data_in;
        end
    end

    // Priority pointer: advances on every grant, holds when nobody asked
    always_ff @(posedge clkin) begin
        if (!nrst_in) begin
            prio <= 1'b0;
        end else begin
            prio <= next_prio_p0;
        end
    end

    // Stage p1: registered write port. x0 writes complete the handshake but
    // never assert the enable; idx/data hold their last value when idle.
    always_ff @(posedge clkin) begin
        if (!nrst_in) begin
            wr_en_p1   <= 1'b0;
            wr_idx_p1  <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= acc_p0 && (sel_idx_p0 != '0);
            if (acc_p0) begin
                wr_idx_p1  <= sel_idx_p0;
                wr_data_p1 <= sel_data_p0;
            end
        end
    end

    assign wr_en_out   = wr_en_p1;
    assign wr_idx_out  = wr_idx_p1;
    assign wr_data_out = wr_data_p1;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_p1;
    logic [NUM_REGS-1:0] set_mask_p0;
    logic [NUM_REGS-1:0] clr_mask_p0;

    // Issue sets, accepted write-back clears; applying set after clear makes
    // a same-index collision keep the bit, since a newer producer is in flight.
    always_comb begin
        set_mask_p0 = '0;
        clr_mask_p0 = '0;
        if (issue_valid_in) begin
            set_mask_p0[issue_idx_in] = 1'b1;
        end
        if (acc_p0) begin
            clr_mask_p0[sel_idx_p0] = 1'b1;
        end
    end

    // Pending-write flags; x0 is never tracked
    always_ff @(posedge clkin) begin
        if (!nrst_in) begin
            busy_p1 <= '0;
        end else begin
            busy_p1 <= ((busy_p1 & ~clr_mask_p0) | set_mask_p0)
                       & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
        end
    end

    assign busy_out = busy_p1;
`else
    logic unused_issue;

    assign unused_issue = ^{issue_valid_in, issue_idx_in};
    assign busy_out     = '0;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts
// readies, the registered write port and busy flags; a monitor compares.
module tb_regfile_wb_arbiter;

    localparam int XW = 32;
    localparam int IW = 5;

    logic          clk;
    logic          nrst_in;
    logic          alu_valid_in;
    logic [IW-1:0] alu_idx_in;
    logic [XW-1:0] alu_data_in;
    logic          alu_ready_out;
    logic          lsu_valid_in;
    logic [IW-1:0] lsu_idx_in;
    logic [XW-1:0] lsu_data_in;
    logic          lsu_ready_out;
    logic          issue_valid_in;
    logic [IW-1:0] issue_idx_in;
    logic          wr_en_out;
    logic [IW-1:0] wr_idx_out;
    logic [XW-1:0] wr_data_out;
    logic [31:0]   busy_out;

    regfile_wb_arbiter #(.XLEN(XW), .IDX_W(IW)) dut (
        .clkin          (clk),
        .nrst_in        (nrst_in),
        .alu_valid_in   (alu_valid_in),
        .alu_idx_in     (alu_idx_in),
        .alu_data_in    (alu_data_in),
        .alu_ready_out  (alu_ready_out),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_idx_in     (lsu_idx_in),
        .lsu_data_in    (lsu_data_in),
        .lsu_ready_out  (lsu_ready_out),
        .issue_valid_in (issue_valid_in),
        .issue_idx_in   (issue_idx_in),
        .wr_en_out      (wr_en_out),
        .wr_idx_out     (wr_idx_out),
        .wr_data_out    (wr_data_out),
        .busy_out       (busy_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          en;
        logic [IW-1:0] idx;
        logic [XW-1:0] data;
        logic [31:0]   busy;
    } wr_exp_t;

    logic [1:0] rdy_q[$];
    wr_exp_t    wr_q[$];

    int n_vec  = 0;
    int n_mis  = 0;

    // Reference state: who wins the next tie, last written idx/data, busy set
    bit            m_lsu_wins_tie;
    logic [31:0]   m_busy;
    logic [IW-1:0] m_idx;
    logic [XW-1:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: sample mid-low-phase; readies refer to this cycle's inputs,
    // the write port and busy flags to the previous rising edge.
    always @(negedge clk) begin
        logic [1:0] r;
        wr_exp_t    w;
        #2;
        if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            chk("ready", {30'd0, alu_ready_out, lsu_ready_out}, {30'd0, r});
        end
        if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            chk("wr_en", {31'd0, wr_en_out}, {31'd0, w.en});
            chk("wr_idx", {27'd0, wr_idx_out}, {27'd0, w.idx});
            chk("wr_data", wr_data_out, w.data);
            chk("busy", busy_out, w.busy);
        end
    end

    // One cycle of stimulus plus the model's prediction of its outcome
    task automatic step(input logic rn,
                        input logic av, input logic [IW-1:0] ai, input logic [XW-1:0] ad,
                        input logic lv, input logic [IW-1:0] li, input logic [XW-1:0] ld,
                        input logic iv, input logic [IW-1:0] ii,
                        output logic ga, output logic gl);
        wr_exp_t e;
        @(negedge clk);
        nrst_in        = rn;
        alu_valid_in   = av;
        alu_idx_in     = ai;
        alu_data_in    = ad;
        lsu_valid_in   = lv;
        lsu_idx_in     = li;
        lsu_data_in    = ld;
        issue_valid_in = iv;
        issue_idx_in   = ii;
        ga = 1'b0;
        gl = 1'b0;
        if (rn) begin
            if (av && lv) begin
                if (m_lsu_wins_tie) gl = 1'b1;
                else                ga = 1'b1;
            end else begin
                ga = av;
                gl = lv;
            end
        end
        rdy_q.push_back({ga, gl});
        @(posedge clk);
        #1;
        if (!rn) begin
            m_lsu_wins_tie = 1'b0;
            m_busy = '0;
            m_idx  = '0;
            m_data = '0;
            e.en   = 1'b0;
        end else begin
            e.en = 1'b0;
            if (ga || gl) begin
                m_idx  = ga ? ai : li;
                m_data = ga ? ad : ld;
                m_lsu_wins_tie = ga;
                e.en = (m_idx != 0);
            end
`ifdef WB_SCOREBOARD_EN
            if (ga || gl) m_busy[m_idx] = 1'b0;
            if (iv) m_busy[ii] = 1'b1;
            m_busy[0] = 1'b0;
`endif
        end
        e.idx  = m_idx;
        e.data = m_data;
        e.busy = m_busy;
        wr_q.push_back(e);
    endtask

    initial begin
        logic          ga, gl;
        logic          pa, pl;
        logic [IW-1:0] ai, li;
        logic [XW-1:0] ad, ld;

        nrst_in = 1'b0;
        alu_valid_in = 1'b0; alu_idx_in = '0; alu_data_in = '0;
        lsu_valid_in = 1'b0; lsu_idx_in = '0; lsu_data_in = '0;
        issue_valid_in = 1'b0; issue_idx_in = '0;
        m_lsu_wins_tie = 1'b0; m_busy = '0; m_idx = '0; m_data = '0;

        // Reset, then a single ALU request
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, ga, gl);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);

        // Contention after reset: ALU, LSU, ALU, LSU back-to-back
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        for (int k = 0; k < 4; k++)
            step(1, 1, 10, 32'hA0A0_0000 + k, 1, 11, 32'hB0B0_0000 + k, 0, 0, ga, gl);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);

        // LSU write to x0
        step(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, ga, gl);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);

        // Scoreboard: issue x7, write back x7, then issue+accept x7 together
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, ga, gl);
        step(1, 1, 7, 32'h77, 0, 0, 0, 0, 0, ga, gl);
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, ga, gl);
        step(1, 1, 7, 32'h78, 0, 0, 0, 1, 7, ga, gl);
        step(1, 0, 0, 0, 0, 0, 0, 1, 9, ga, gl);
        step(1, 0, 0, 0, 1, 3, 32'h33, 1, 4, ga, gl);

        // Reset mid-operation, then contention must grant ALU first
        step(1, 1, 3, 32'h3333, 0, 0, 0, 1, 12, ga, gl);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        step(1, 1, 1, 32'h1111, 1, 2, 32'h2222, 0, 0, ga, gl);
        step(1, 0, 0, 0, 1, 2, 32'h2222, 0, 0, ga, gl);

        // Randomized traffic with requesters honouring the hold rule
        pa = 1'b0; pl = 1'b0; ai = '0; li = '0; ad = '0; ld = '0;
        for (int n = 0; n < 600; n++) begin
            logic rn, iv;
            logic [IW-1:0] ii;
            if (!pa && ($urandom_range(2) != 0)) begin
                pa = 1'b1; ai = IW'($urandom); ad = $urandom;
            end
            if (!pl && ($urandom_range(2) != 0)) begin
                pl = 1'b1; li = IW'($urandom); ld = $urandom;
            end
            rn = ($urandom_range(63) != 0);
            iv = $urandom_range(1) != 0;
            ii = IW'($urandom);
            step(rn, pa, ai, ad, pl, li, ld, iv, ii, ga, gl);
            if (!rn || ga) pa = 1'b0;
            if (!rn || gl) pl = 1'b0;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);

        repeat (3) @(negedge clk);
        #5;
        if (rdy_q.size() != 0 || wr_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d ready and %0d write expectations left, expected 0",
                     rdy_q.size(), wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
